data_memory_io: RTL and testbench

Parametrised successor of the single-port data memory. It provides word-addressed RAM plus three memory-mapped I/O ports at the top of the address space: seven-segment display register (P1), debounced-free button event flag (P2), and switches (P3). Asynchronous inputs are synchronised and button presses are latched as sticky events. Read latency is selectable, so the block serves both single-cycle and pipelined cores.

---
 rtl/data_memory_io.sv | 104 ++++++++++
 tb/tb_data_memory_io.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_io.sv
// Word RAM with display/button/switch ports mapped at the top three addresses; read latency 0 or 1 (READ_REG).
// No backpressure: a write is taken on every rising edge with we high, and a read is always valid.
module data_memory_io #(
    parameter int N        = 8,
    parameter int M        = 8,
    parameter int READ_REG = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] addr,
    input  logic [N-1:0] wdata,
    input  logic         we,
    output logic [N-1:0] rdata,
    input  logic         btn_in,
    input  logic [N-1:0] sw_in,
    output logic [N-1:0] disp_out,
    output logic         btn_flag
);

    localparam int           DEPTH     = 2**M;
    localparam int           RAM_WORDS = DEPTH - 3;
    localparam logic [M-1:0] ADDR_P1   = M'(DEPTH - 1);
    localparam logic [M-1:0] ADDR_P2   = M'(DEPTH - 2);
    localparam logic [M-1:0] ADDR_P3   = M'(DEPTH - 3);

    logic [N-1:0] mem [RAM_WORDS];

    logic         b1_q, b2_q, b3_q;
    logic [N-1:0] sw1_q, sw2_q;
    logic [N-1:0] disp_q, disp_d;
    logic         flag_q, flag_d;
    logic         is_ram;
    logic         btn_evt;
    logic [N-1:0] rd_mux;

    assign is_ram  = (addr < ADDR_P3);
    assign btn_evt = b2_q & ~b3_q;

    // RAM is not reset, but a write on an edge held in reset is discarded.
    always_ff @(posedge clk) begin
        if (rst_n && we && is_ram) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        disp_d = disp_q;
        flag_d = flag_q;
        if (we && addr == ADDR_P1) disp_d = wdata;
        if (we && addr == ADDR_P2) flag_d = 1'b0;
        // A new press beats a same-cycle clear so no event is lost.
        if (btn_evt) flag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b1_q   <= 1'b0;
            b2_q   <= 1'b0;
            b3_q   <= 1'b0;
            sw1_q  <= '0;
            sw2_q  <= '0;
            disp_q <= '0;
            flag_q <= 1'b0;
        end else begin
            b1_q   <= btn_in;
            b2_q   <= b1_q;
            b3_q   <= b2_q;
            sw1_q  <= sw_in;
            sw2_q  <= sw1_q;
            disp_q <= disp_d;
            flag_q <= flag_d;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (is_ram) begin
            rd_mux = mem[addr];
        end else if (addr == ADDR_P1) begin
            rd_mux = disp_q;
        end else if (addr == ADDR_P2) begin
            rd_mux = {{(N-1){1'b0}}, flag_q};
        end else begin
            rd_mux = sw2_q;
        end
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [N-1:0] rdata_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rdata_q <= '0;
                else        rdata_q <= rd_mux;
            end
            assign rdata = rdata_q;
        end else begin : g_rd_comb
            assign rdata = rd_mux;
        end
    endgenerate

    assign disp_out = disp_q;
    assign btn_flag = flag_q;

endmodule

// File: tb/tb_data_memory_io.sv
// Drives a combinational-read and a registered-read instance with the same stimulus and checks both against a behavioural model.
module tb_data_memory_io;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       we = 1'b0;
    logic       btn_in = 1'b0;
    logic [7:0] sw_in = '0;
    logic [7:0] rd0, rd1, disp0, disp1;
    logic       flag0, flag1;

    always #5 clk = ~clk;

    data_memory_io #(.N(8), .M(8), .READ_REG(0)) u_rr0 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .rdata(rd0),
        .btn_in(btn_in), .sw_in(sw_in), .disp_out(disp0), .btn_flag(flag0)
    );

    data_memory_io #(.N(8), .M(8), .READ_REG(1)) u_rr1 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .rdata(rd1),
        .btn_in(btn_in), .sw_in(sw_in), .disp_out(disp1), .btn_flag(flag1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: memory contents, I/O registers, and sample histories of the raw inputs
    logic [7:0] m_mem [256];
    bit         m_vld [256];
    logic [7:0] m_disp = '0;
    bit         m_flag = 1'b0;
    bit         btn_h [$] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] sw_h  [$] = '{8'h00, 8'h00};
    logic [7:0] m_rd1 = '0;
    bit         m_rd1_vld = 1'b1;
    bit         chk_on = 1'b0;
    logic [7:0] mv, cv;
    bit         mk, ck, mev;

    // Switch value visible at the port is the sample taken two edges back; btn_h[0] is the newest sample.
    function automatic void m_read(input logic [7:0] a, output logic [7:0] v, output bit known);
        known = 1'b1;
        if (a == 8'hFF)      v = m_disp;
        else if (a == 8'hFE) v = {7'b0, m_flag};
        else if (a == 8'hFD) v = sw_h[1];
        else begin
            v     = m_mem[a];
            known = m_vld[a];
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_disp    = '0;
            m_flag    = 1'b0;
            btn_h     = '{1'b0, 1'b0, 1'b0};
            sw_h      = '{8'h00, 8'h00};
            m_rd1     = '0;
            m_rd1_vld = 1'b1;
        end else begin
            m_read(addr, mv, mk);
            m_rd1     = mv;
            m_rd1_vld = mk;
            // Press seen two edges ago after a release three edges ago
            mev = btn_h[1] && !btn_h[2];
            if (we) begin
                if (addr < 8'hFD) begin
                    m_mem[addr] = wdata;
                    m_vld[addr] = 1'b1;
                end else if (addr == 8'hFF) begin
                    m_disp = wdata;
                end else if (addr == 8'hFE) begin
                    m_flag = 1'b0;
                end
            end
            if (mev) m_flag = 1'b1;
            btn_h.push_front(btn_in);
            void'(btn_h.pop_back());
            sw_h.push_front(sw_in);
            void'(sw_h.pop_back());
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            m_read(addr, cv, ck);
            if (ck) chk("model_rdata_rr0", rd0, cv);
            if (m_rd1_vld) chk("model_rdata_rr1", rd1, m_rd1);
            chk("model_disp_rr0", disp0, m_disp);
            chk("model_disp_rr1", disp1, m_disp);
            chk("model_flag_rr0", {7'b0, flag0}, {7'b0, m_flag});
            chk("model_flag_rr1", {7'b0, flag1}, {7'b0, m_flag});
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] d, input logic w);
        addr  = a;
        wdata = d;
        we    = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("reset_disp", disp0, 8'h00);
        chk("reset_flag", {7'b0, flag0}, 8'h00);
        chk("reset_rdata_rr1", rd1, 8'h00);
        #9 rst_n = 1'b1;
        chk_on = 1'b1;

        // RAM write/read
        drive(8'd3, 8'h5A, 1'b1); tick();
        drive(8'd4, 8'hC3, 1'b1); tick();
        drive(8'd3, 8'h00, 1'b0); #1;
        chk("ram3_rr0", rd0, 8'h5A);
        tick();
        chk("ram3_rr1", rd1, 8'h5A);
        drive(8'd4, 8'h00, 1'b0); #1;
        chk("ram4_rr0", rd0, 8'hC3);
        tick();
        chk("ram4_rr1", rd1, 8'hC3);
        chk("disp_idle", disp0, 8'h00);
        chk("flag_idle", {7'b0, flag0}, 8'h00);

        // Display port
        drive(8'hFF, 8'h7E, 1'b1); #1;
        chk("disp_before_edge", disp0, 8'h00);
        tick();
        chk("disp_after_edge", disp0, 8'h7E);
        drive(8'hFF, 8'h00, 1'b0); #1;
        chk("disp_readback", rd0, 8'h7E);

        // Button: flag rises exactly on the third edge
        btn_in = 1'b1;
        tick(); chk("btn_edge1", {7'b0, flag0}, 8'h00);
        tick(); chk("btn_edge2", {7'b0, flag0}, 8'h00);
        tick(); chk("btn_edge3", {7'b0, flag0}, 8'h01);
        repeat (7) tick();
        drive(8'hFE, 8'h00, 1'b0); #1;
        chk("btn_read_p2", rd0, 8'h01);
        drive(8'hFE, 8'hFF, 1'b1); tick();
        chk("btn_clear", {7'b0, flag0}, 8'h00);
        drive(8'h00, 8'h00, 1'b0);
        repeat (4) tick();
        chk("btn_held_single_event", {7'b0, flag0}, 8'h00);
        btn_in = 1'b0;
        repeat (3) tick();
        btn_in = 1'b1;
        repeat (3) tick();
        chk("btn_repress", {7'b0, flag0}, 8'h01);

        // Press event coincides with a clear: set wins
        drive(8'hFE, 8'h00, 1'b1); tick();
        chk("btn_clear2", {7'b0, flag0}, 8'h00);
        drive(8'h00, 8'h00, 1'b0);
        btn_in = 1'b0;
        repeat (3) tick();
        btn_in = 1'b1;
        tick(); tick();
        drive(8'hFE, 8'h00, 1'b1); tick();
        chk("btn_set_beats_clear", {7'b0, flag0}, 8'h01);
        drive(8'h00, 8'h00, 1'b0);
        btn_in = 1'b0;

        // Switches: two-edge synchroniser, plus one for the registered read
        sw_in = 8'hA5;
        drive(8'hFD, 8'h00, 1'b0); #1;
        chk("sw_edge0", rd0, 8'h00);
        tick(); chk("sw_edge1", rd0, 8'h00);
        tick(); chk("sw_edge2_rr0", rd0, 8'hA5);
        chk("sw_edge2_rr1", rd1, 8'h00);
        tick(); chk("sw_edge3_rr1", rd1, 8'hA5);
        drive(8'hFD, 8'hFF, 1'b1); tick();
        drive(8'hFD, 8'h00, 1'b0); #1;
        chk("sw_write_ignored", rd0, 8'hA5);

        // Registered read is read-first
        drive(8'd9, 8'h11, 1'b1); tick();
        drive(8'd9, 8'h22, 1'b1); tick();
        chk("rr1_read_first", rd1, 8'h11);
        drive(8'd9, 8'h00, 1'b0); tick();
        chk("rr1_new_value", rd1, 8'h22);

        // Asynchronous reset mid-operation; write on the held edge is dropped
        drive(8'd9, 8'h33, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rr1", rd1, 8'h00);
        chk("async_rst_disp", disp0, 8'h00);
        chk("async_rst_flag", {7'b0, flag1}, 8'h00);
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(8'd9, 8'h00, 1'b0); #1;
        chk("rst_write_dropped", rd0, 8'h22);
        tick();

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       addr = 8'($urandom_range(0, 15));
                1:       addr = 8'(8'hFD + $urandom_range(0, 2));
                2:       addr = 8'($urandom);
                default: addr = 8'($urandom_range(0, 7));
            endcase
            we    = ($urandom_range(0, 2) == 0);
            wdata = 8'($urandom);
            if ($urandom_range(0, 6) == 0) btn_in = ~btn_in;
            if ($urandom_range(0, 9) == 0) sw_in = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                #3 rst_n = 1'b1;
            end
            tick();
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
